// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - request/result and shared-slice bundle for nibble_serial_add_ctrl
//
// Purpose: groups the requester handshake, the result registers and the
// shared 4-bit adder slice connection into one bundle.
// Signals:
//   start, a, b, cin       requester -> controller (operation request)
//   busy, done             controller -> requester (status)
//   sum, cout, ovf         controller -> requester (held result)
//   add_x, add_y, add_cin  controller -> slice (operands, quiet when idle)
//   add_s, add_cout        slice -> controller (combinational slice result)
// Modports: master = requester plus slice side, slave = controller side.

interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [3:0]   add_x;
    logic [3:0]   add_y;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    modport master (
        output start, a, b, cin, add_s, add_cout,
        input  busy, done, sum, cout, ovf, add_x, add_y, add_cin
    );

    modport slave (
        input  start, a, b, cin, add_s, add_cout,
        output busy, done, sum, cout, ovf, add_x, add_y, add_cin
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - wide adder sequenced over one shared 4-bit slice
//
// Purpose: adds two W-bit operands (W = 4*NIBBLES) one nibble per clock,
// LSB nibble first, through an external 4-bit ripple-carry slice.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    nibble_serial_add_ctrl_if.slave: start/a/b/cin request,
//          busy/done status, sum/cout/ovf held result,
//          add_x/add_y/add_cin to the slice, add_s/add_cout from it.

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_add_ctrl_if.slave       bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    logic          run;
    logic [IW+1:0] bit_base;

    assign run      = (state_q == S_RUN);
    assign bit_base = {idx_q, 2'b00};

    // The slice is shared, so it only sees our operands while we own it.
    assign bus.add_x   = run ? a_q[bit_base +: 4] : 4'h0;
    assign bus.add_y   = run ? b_q[bit_base +: 4] : 4'h0;
    assign bus.add_cin = run ? carry_q : 1'b0;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // sum/cout/ovf are left alone: the previous result stays
                    // visible until each nibble is overwritten.
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q[bit_base +: 4] <= bus.add_s;
                    carry_q              <= bus.add_cout;
                    idx_q                <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Overflow: operand signs agree but the MSB nibble's
                        // sum bit disagrees with them.
                        cout_q  <= bus.add_cout;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - randomized self-checking bench for nibble_serial_add_ctrl

module tb_nibble_serial_add_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();

    // Shared 4-bit slice: purely combinational adder.
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {4'b0, bus.add_cin};

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline relative to the edge where a start was accepted.
    int           ecount = 0;
    int           k_acc  = -1;
    logic [W-1:0] al = '0, bl = '0;
    logic         cl = 1'b0;
    logic [W-1:0] old_sum = '0, new_sum = '0;
    logic         old_cout = 1'b0, new_cout = 1'b0, old_ovf = 1'b0, new_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecount = 0; k_acc = -1;
            al = '0; bl = '0; cl = 1'b0;
            old_sum = '0; new_sum = '0;
            old_cout = 1'b0; new_cout = 1'b0; old_ovf = 1'b0; new_ovf = 1'b0;
        end else begin
            bit running;
            ecount++;
            running = (k_acc >= 0) && (ecount - k_acc >= 1) && (ecount - k_acc <= N);
            if (bus.start && !running) begin
                if (k_acc >= 0) begin
                    old_sum = new_sum; old_cout = new_cout; old_ovf = new_ovf;
                end
                k_acc = ecount;
                al = bus.a; bl = bus.b; cl = bus.cin;
                {new_cout, new_sum} = {1'b0, al} + {1'b0, bl} + {{W{1'b0}}, cl};
                new_ovf = (al[W-1] == bl[W-1]) && (new_sum[W-1] != al[W-1]);
            end
        end
    end

    always @(negedge clk) begin
        int           p;
        logic [W:0]   one, m, part;
        logic [W-1:0] tx, ty;
        logic         e_busy, e_done, e_cin, e_cout, e_ovf;
        logic [3:0]   e_x, e_y;
        logic [W-1:0] e_sum;
        one = 1;
        p = ecount - k_acc;
        e_busy = (k_acc >= 0) && (p >= 0) && (p <= N - 1);
        e_done = (k_acc >= 0) && (p == N);
        e_x = 4'h0; e_y = 4'h0; e_cin = 1'b0;
        e_sum = old_sum; e_cout = old_cout; e_ovf = old_ovf;
        if (e_busy) begin
            tx = al >> (4 * p); ty = bl >> (4 * p);
            e_x = tx[3:0]; e_y = ty[3:0];
            m = (one << (4 * p)) - 1;
            part = (({1'b0, al} & m) + ({1'b0, bl} & m) + {{W{1'b0}}, cl}) >> (4 * p);
            e_cin = part[0];
            e_sum = (new_sum & m[W-1:0]) | (old_sum & ~m[W-1:0]);
        end else if (k_acc >= 0) begin
            e_sum = new_sum; e_cout = new_cout; e_ovf = new_ovf;
        end
        chk("busy",    {{W{1'b0}}, bus.busy},    {{W{1'b0}}, e_busy});
        chk("done",    {{W{1'b0}}, bus.done},    {{W{1'b0}}, e_done});
        chk("sum",     {1'b0, bus.sum},          {1'b0, e_sum});
        chk("cout",    {{W{1'b0}}, bus.cout},    {{W{1'b0}}, e_cout});
        chk("ovf",     {{W{1'b0}}, bus.ovf},     {{W{1'b0}}, e_ovf});
        chk("add_x",   {{(W-3){1'b0}}, bus.add_x}, {{(W-3){1'b0}}, e_x});
        chk("add_y",   {{(W-3){1'b0}}, bus.add_y}, {{(W-3){1'b0}}, e_y});
        chk("add_cin", {{W{1'b0}}, bus.add_cin}, {{W{1'b0}}, e_cin});
    end

    // Directed operation with literal expectations; returns in the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit poke, input logic first_cin);
        int i, bcnt;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = c;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bcnt = 0;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) chk("first_add_cin", {{W{1'b0}}, bus.add_cin}, {{W{1'b0}}, first_cin});
            if (poke && i == 1) begin
                bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1;
            end
            if (poke && i == 2) bus.start = 1'b0;
            if (bus.done) break;
            if (bus.busy) bcnt++;
        end
        chk("done_latency", i,  N);
        chk("busy_cycles",  bcnt, N);
        chk("lit_sum",  {1'b0, bus.sum},       {1'b0, es});
        chk("lit_cout", {{W{1'b0}}, bus.cout}, {{W{1'b0}}, ec});
        chk("lit_ovf",  {{W{1'b0}}, bus.ovf},  {{W{1'b0}}, eo});
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {{W{1'b0}}, bus.busy}, 0);
        chk("rst_sum",  {1'b0, bus.sum},       0);
        @(posedge clk); #2 rst_n = 1'b1;

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(16'h9009, 16'h0660, 1'b0, 16'h9669, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h9009, 16'h0660, 1'b1, 16'h966A, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back start in the done cycle.
        bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0;
        @(posedge clk); #2 bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_busy",      {{W{1'b0}}, bus.busy}, 1);
        chk("b2b_done",      {{W{1'b0}}, bus.done}, 0);
        chk("b2b_held_sum",  {1'b0, bus.sum},       {1'b0, 16'h2345});
        repeat (N) @(negedge clk);
        chk("b2b_sum",  {1'b0, bus.sum},       {1'b0, 16'h0100});
        chk("b2b_cout", {{W{1'b0}}, bus.cout}, 0);
        chk("b2b_doneflag", {{W{1'b0}}, bus.done}, 1);

        // Reset mid-operation.
        @(posedge clk); #2;
        bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h1234; bus.cin = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {{W{1'b0}}, bus.busy}, 0);
        chk("abort_done", {{W{1'b0}}, bus.done}, 0);
        chk("abort_sum",  {1'b0, bus.sum},       0);
        chk("abort_cout", {{W{1'b0}}, bus.cout}, 0);
        chk("abort_ovf",  {{W{1'b0}}, bus.ovf},  0);
        @(posedge clk); #2 rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic: starts land in idle, run and done cycles alike.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            bus.start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       bus.a = 16'hFFFF;
                1:       bus.a = 16'h8000;
                default: bus.a = W'($urandom);
            endcase
            bus.b   = ($urandom_range(0, 4) == 0) ? 16'h7FFF : W'($urandom);
            bus.cin = 1'($urandom);
        end
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (N + 3) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a wide add by time-multiplexing one external 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Holds the operands and a carry register, steers the slice inputs, and captures the slice outputs each cycle.
- Sits between a requesting datapath (start/done handshake) and the shared 4-bit adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  W  operand A, latched on an accepted start.
- b  input  W  operand B, latched on an accepted start.
- cin  input  1  carry-in of the whole operation, latched on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  W  result register; held until the next accepted start.
- cout  output  1  carry-out of the MSB nibble; held with sum.
- ovf  output  1  two's-complement overflow; held with sum.
- add_x  output  4  to slice operand X.
- add_y  output  4  to slice operand Y.
- add_cin  output  1  to slice carry-in.
- add_s  input  4  slice sum; combinational function of add_x, add_y and add_cin.
- add_cout  input  1  slice carry-out.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, cout, ovf = 0; sum = 0; idx = 0; carry register = 0; operand registers = 0.
- States:
  - IDLE -> RUN on start=1.
  - RUN stays RUN while idx < NIBBLES-1. At idx = NIBBLES-1 the transition is RUN -> DONE.
  - DONE lasts exactly one cycle with done=1. From DONE: go to RUN if start=1, otherwise go to IDLE.
- Accepted start (in IDLE or DONE):
  - a_reg <= a, b_reg <= b, carry <= cin, idx <= 0.
  - sum, cout and ovf keep their previous values until overwritten nibble by nibble.
- In RUN, combinational outputs:
  - add_x = a_reg[4*idx +: 4], add_y = b_reg[4*idx +: 4], add_cin = carry.
- In RUN, on each rising edge:
  - sum[4*idx +: 4] <= add_s; carry <= add_cout; idx <= idx+1.
- On the edge that leaves RUN:
  - cout <= add_cout.
  - ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]).
- Outside RUN, add_x, add_y and add_cin are driven 0 so the shared slice sees quiet inputs.
- Latency: start sampled at edge k -> busy=1 from k through k+NIBBLES-1 -> done=1 in the cycle after edge k+NIBBLES. Total NIBBLES+1 cycles from start to done.
- start while busy=1 is ignored: no latch, no queueing, no effect on the operation in progress.
- start in the DONE cycle is accepted back-to-back; done and the next busy are never high in the same cycle.
- The result is modulo 2^W, with the carry reported on cout. No saturation.
- Reset asserted mid-operation aborts immediately. After rst_n rises, the first start behaves exactly as after power-up.
- cin is fully general: add_cin in the first RUN cycle equals the latched cin.

Test Plan:
- NIBBLES=4, a=0xFFFF, b=0xFFFF, cin=0, start for 1 cycle -> busy for 4 cycles, done on cycle 5; sum=0xFFFE, cout=1, ovf=0; add_x/add_y observed as 0xF each RUN cycle.
- Same operands, cin=1 -> sum=0xFFFF, cout=1, ovf=0; add_cin=1 in the first RUN cycle.
- a=0x9009, b=0x0660, cin=0 -> sum=0x9669, cout=0, ovf=0. Then the same operands with cin=1 -> sum=0x966A, cout=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Start 0x1234+0x1111 and re-pulse start with different operands during RUN -> ignored; sum=0x2345. Then start, and pull rst_n low after 2 RUN cycles -> busy, done, sum, cout, ovf all 0 at once; next start of 0x0001+0x0001 gives 0x0002.
- Assert start during the done cycle with a=0x00FF, b=0x0001 -> busy on the next cycle, no idle gap; second result sum=0x0100, cout=0; the first result was held until nibble 0 was overwritten.
